// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the I/D memory bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    localparam logic [2:0] KSEG0 = 3'b100;
    localparam logic [2:0] KSEG1 = 3'b101;

    localparam int RUN_CNT_W = 4;
    typedef logic [RUN_CNT_W-1:0] run_cnt_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Pipeline-side (I and D ports) and memory-side bus signals of the arbiter.
// master = the arbiter itself, slave = its environment (pipeline plus memory).
interface mem_bus_arbiter_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport master (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
    );

    modport slave (
        output inst_req, inst_addr,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
    );

endinterface

// File: rtl/mem_bus_arbiter_addr_map.sv
// Virtual-to-physical map: kseg0/kseg1 fold onto the low 512 MiB, all else passes through.
module mem_bus_arbiter_addr_map
    import mem_bus_arbiter_pkg::*;
#(
    parameter bit ADDR_MAP_EN = 1'b1
) (
    input  logic [31:0] i_addr,
    output logic [31:0] o_addr
);

    always_comb begin
        o_addr = i_addr;
        if (ADDR_MAP_EN && ((i_addr[31:29] == KSEG0) || (i_addr[31:29] == KSEG1))) begin
            o_addr = {3'b000, i_addr[28:0]};
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between instruction fetch (I)
// and data (D); D has priority, bounded by a run counter that guarantees I progress.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = 4,
    parameter bit          ADDR_MAP_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.master bus_if
);

    localparam run_cnt_t MAX_RUN = run_cnt_t'(MAX_DATA_RUN);

    state_t      r_state;
    state_t      w_state_next;
    owner_t      r_owner;
    run_cnt_t    r_run_cnt;

    logic        r_bus_req;
    logic        r_bus_wr;
    logic [3:0]  r_bus_wstrb;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;

    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_grant;
    logic        w_addr_ack;
    logic        w_data_ack;
    logic [31:0] w_sel_addr;
    logic [31:0] w_phys_addr;

    // D loses only when I is waiting and D has already used up its run.
    always_comb begin
        w_grant_d  = bus_if.data_req && !(bus_if.inst_req && (r_run_cnt == MAX_RUN));
        w_grant_i  = !w_grant_d && bus_if.inst_req;
        w_grant    = (r_state == ST_IDLE) && (w_grant_d || w_grant_i);
        w_sel_addr = w_grant_d ? bus_if.data_addr : bus_if.inst_addr;
    end

    mem_bus_arbiter_addr_map #(
        .ADDR_MAP_EN (ADDR_MAP_EN)
    ) u_addr_map (
        .i_addr (w_sel_addr),
        .o_addr (w_phys_addr)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_addr_ack   = 1'b0;
        w_data_ack   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grant) w_state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (bus_if.bus_addr_ok) begin
                    w_addr_ack = 1'b1;
                    if (bus_if.bus_data_ok) begin
                        w_data_ack   = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bus_if.bus_data_ok) begin
                    w_data_ack   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWNER_I;
            r_run_cnt   <= '0;
            r_bus_req   <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_wstrb <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_next;
            if (w_grant) begin
                r_owner     <= w_grant_d ? OWNER_D : OWNER_I;
                r_bus_req   <= 1'b1;
                r_bus_wr    <= w_grant_d & bus_if.data_wr;
                r_bus_wstrb <= w_grant_d ? bus_if.data_wstrb : 4'b0000;
                r_bus_addr  <= w_phys_addr;
                r_bus_wdata <= w_grant_d ? bus_if.data_wdata : 32'h0;
                if (!w_grant_d) begin
                    r_run_cnt <= '0;
                end else if (bus_if.inst_req && (r_run_cnt != '1)) begin
                    r_run_cnt <= r_run_cnt + 1'b1;
                end
            end else if (w_addr_ack) begin
                r_bus_req <= 1'b0;
            end
        end
    end

    assign bus_if.bus_req      = r_bus_req;
    assign bus_if.bus_wr       = r_bus_wr;
    assign bus_if.bus_wstrb    = r_bus_wstrb;
    assign bus_if.bus_addr     = r_bus_addr;
    assign bus_if.bus_wdata    = r_bus_wdata;

    assign bus_if.inst_addr_ok = w_addr_ack && (r_owner == OWNER_I);
    assign bus_if.data_addr_ok = w_addr_ack && (r_owner == OWNER_D);
    assign bus_if.inst_data_ok = w_data_ack && (r_owner == OWNER_I);
    assign bus_if.data_data_ok = w_data_ack && (r_owner == OWNER_D);
    assign bus_if.inst_rdata   = bus_if.bus_rdata;
    assign bus_if.data_rdata   = bus_if.bus_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: directed scenarios plus randomized I/D request mixes,
// each grant predicted by a priority/run-count reference model.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int MAX_RUN = 4;

    logic clk;
    logic rst;

    int n_vec  = 0;
    int n_miss = 0;
    int m_run  = 0;
    logic [15:0] order;

    mem_bus_arbiter_if ifc ();
    mem_bus_arbiter_if ifn ();

    mem_bus_arbiter #(.MAX_DATA_RUN(MAX_RUN), .ADDR_MAP_EN(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (ifc)
    );

    mem_bus_arbiter #(.MAX_DATA_RUN(MAX_RUN), .ADDR_MAP_EN(1'b0)) dut_nm (
        .clk    (clk),
        .rst    (rst),
        .bus_if (ifn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_phys(input logic [31:0] va, input bit en);
        if (en && va >= 32'h8000_0000 && va <= 32'hBFFF_FFFF) return va & 32'h1FFF_FFFF;
        return va;
    endfunction

    task automatic new_d_payload();
        case ($urandom_range(0, 3))
            0:       ifc.data_addr = 32'h8000_0000 | ($urandom & 32'h1FFF_FFFC);
            1:       ifc.data_addr = 32'hA000_0000 | ($urandom & 32'h1FFF_FFFC);
            2:       ifc.data_addr = 32'hC000_0000 | ($urandom & 32'h3FFF_FFFC);
            default: ifc.data_addr = $urandom & 32'h7FFF_FFFC;
        endcase
        ifc.data_wr    = 1'($urandom_range(0, 1));
        ifc.data_wstrb = 4'($urandom);
        ifc.data_wdata = $urandom;
    endtask

    task automatic new_i_addr();
        ifc.inst_addr = ($urandom_range(0, 1) == 1) ? (32'hBFC0_0000 | ($urandom & 32'h000F_FFFC))
                                                    : ($urandom & 32'hFFFF_FFFC);
    endtask

    task automatic check_data(input bit own_d, input logic [31:0] rd);
        check("data_ok_owner", own_d ? ifc.data_data_ok : ifc.inst_data_ok, 1);
        check("data_ok_other", own_d ? ifc.inst_data_ok : ifc.data_data_ok, 0);
        check("rdata_owner",   own_d ? ifc.data_rdata   : ifc.inst_rdata,   rd);
    endtask

    // Masters hold each request until accepted, then present the next one;
    // the slave answers with addr_lat/data_lat cycle delays (negative = random).
    task automatic run_mix(input int n_i, input int n_d, input int addr_lat, input int data_lat);
        int rem_i = n_i;
        int rem_d = n_d;
        int guard;
        int a_lat;
        int d_lat;
        bit own_d;
        logic [31:0] rd;
        ifc.inst_req = (rem_i > 0);
        ifc.data_req = (rem_d > 0);
        while (rem_i > 0 || rem_d > 0) begin
            guard = 0;
            do begin
                @(posedge clk); #1;
                guard++;
            end while (!ifc.bus_req && guard < 6);
            if (!ifc.bus_req) begin
                check("grant_timeout", ifc.bus_req, 1);
                ifc.inst_req = 1'b0;
                ifc.data_req = 1'b0;
                return;
            end
            check("grant_latency", guard, 1);
            own_d = ifc.data_req && !(ifc.inst_req && m_run == MAX_RUN);
            if (!own_d)             m_run = 0;
            else if (ifc.inst_req)  m_run = (m_run == 15) ? 15 : m_run + 1;
            check("bus_addr", ifc.bus_addr, exp_phys(own_d ? ifc.data_addr : ifc.inst_addr, 1'b1));
            check("bus_wr",    ifc.bus_wr,    own_d ? ifc.data_wr : 1'b0);
            check("bus_wstrb", ifc.bus_wstrb, own_d ? ifc.data_wstrb : 4'b0000);
            if (own_d) check("bus_wdata", ifc.bus_wdata, ifc.data_wdata);
            check("run_cnt", 32'(dut.r_run_cnt), m_run);

            a_lat = (addr_lat < 0) ? $urandom_range(0, 2) : addr_lat;
            repeat (a_lat) begin
                @(posedge clk); #1;
                check("req_held", ifc.bus_req, 1);
                check("no_early_ack", {ifc.inst_addr_ok, ifc.data_addr_ok}, 0);
            end

            d_lat = (data_lat < 0) ? $urandom_range(0, 3) : data_lat;
            rd = $urandom;
            ifc.bus_addr_ok = 1'b1;
            if (d_lat == 0) begin
                ifc.bus_data_ok = 1'b1;
                ifc.bus_rdata   = rd;
            end
            #1;
            check("addr_ok_owner", own_d ? ifc.data_addr_ok : ifc.inst_addr_ok, 1);
            check("addr_ok_other", own_d ? ifc.inst_addr_ok : ifc.data_addr_ok, 0);
            order = {order[14:0], ifc.data_addr_ok};
            if (d_lat == 0) check_data(own_d, rd);
            @(posedge clk); #1;
            ifc.bus_addr_ok = 1'b0;
            ifc.bus_data_ok = 1'b0;
            if (own_d) begin
                rem_d--;
                if (rem_d > 0) new_d_payload();
                ifc.data_req = (rem_d > 0);
            end else begin
                rem_i--;
                new_i_addr();
                ifc.inst_req = (rem_i > 0);
            end
            check("req_cleared", ifc.bus_req, 0);
            if (d_lat == 0) begin
                check("idle_after_both", 32'(dut.r_state), 32'(ST_IDLE));
            end else begin
                repeat (d_lat - 1) begin
                    @(posedge clk); #1;
                    check("no_early_data", {ifc.inst_data_ok, ifc.data_data_ok}, 0);
                end
                ifc.bus_data_ok = 1'b1;
                ifc.bus_rdata   = rd;
                #1;
                check_data(own_d, rd);
                @(posedge clk); #1;
                ifc.bus_data_ok = 1'b0;
                check("req_low_in_idle", ifc.bus_req, 0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        order = '0;
        ifc.inst_req = 0; ifc.inst_addr = 0; ifc.data_req = 0; ifc.data_wr = 0;
        ifc.data_wstrb = 0; ifc.data_addr = 0; ifc.data_wdata = 0;
        ifc.bus_addr_ok = 0; ifc.bus_data_ok = 0; ifc.bus_rdata = 0;
        ifn.inst_req = 0; ifn.inst_addr = 0; ifn.data_req = 0; ifn.data_wr = 0;
        ifn.data_wstrb = 0; ifn.data_addr = 0; ifn.data_wdata = 0;
        ifn.bus_addr_ok = 0; ifn.bus_data_ok = 0; ifn.bus_rdata = 0;

        // Reset state
        #2;
        check("rst_bus_req",  ifc.bus_req, 0);
        check("rst_bus_addr", ifc.bus_addr, 0);
        check("rst_bus_wr",   {ifc.bus_wr, ifc.bus_wstrb}, 0);
        check("rst_acks", {ifc.inst_addr_ok, ifc.inst_data_ok, ifc.data_addr_ok, ifc.data_data_ok}, 0);
        check("rst_run_cnt", 32'(dut.r_run_cnt), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: D read through kseg0
        ifc.data_addr = 32'h8000_1000; ifc.data_wr = 1'b0; ifc.data_wstrb = 4'b0000;
        ifc.data_wdata = 32'h0;
        run_mix(0, 1, 1, 2);

        // 2: simultaneous I and D, D write through kseg1 wins, then I
        ifc.inst_addr  = 32'hBFC0_0100;
        ifc.data_addr  = 32'hA000_0040; ifc.data_wr = 1'b1;
        ifc.data_wstrb = 4'b0011;       ifc.data_wdata = 32'h1234_5678;
        order = '0;
        run_mix(1, 1, 1, 1);
        check("t2_order", order[1:0], 2'b10);

        // 3: D run limit with I held
        order = '0;
        new_d_payload();
        new_i_addr();
        run_mix(1, 6, 0, 1);
        check("t3_order", order[6:0], 7'b1111011);

        // 4: I read with addr_ok and data_ok together
        ifc.inst_addr = 32'hBFC0_0000;
        run_mix(1, 0, 0, 0);

        // 5: asynchronous reset in DATA
        ifc.data_addr = 32'h0000_2000; ifc.data_wr = 1'b0;
        ifc.inst_addr = 32'h8000_0100;
        ifc.data_req = 1'b1; ifc.inst_req = 1'b1;
        @(posedge clk); #1;
        check("t5_grant", ifc.bus_req, 1);
        check("t5_run_cnt", 32'(dut.r_run_cnt), 1);
        ifc.bus_addr_ok = 1'b1;
        @(posedge clk); #1;
        ifc.bus_addr_ok = 1'b0;
        ifc.data_req    = 1'b0;
        #3;
        rst = 1'b1;
        ifc.bus_data_ok = 1'b1;
        #1;
        check("t5_bus_req",  ifc.bus_req, 0);
        check("t5_bus_addr", ifc.bus_addr, 0);
        check("t5_payload",  {ifc.bus_wr, ifc.bus_wstrb, ifc.bus_wdata[26:0]}, 0);
        check("t5_acks", {ifc.inst_addr_ok, ifc.inst_data_ok, ifc.data_addr_ok, ifc.data_data_ok}, 0);
        check("t5_run_cnt", 32'(dut.r_run_cnt), 0);
        @(posedge clk); #1;
        ifc.bus_data_ok = 1'b0;
        rst = 1'b0;
        m_run = 0;
        run_mix(1, 0, 1, 1);

        // 6: map disabled, address passes unchanged
        ifn.data_addr = 32'h9FFF_FFFC; ifn.data_wr = 1'b0; ifn.data_req = 1'b1;
        @(posedge clk); #1;
        check("t6_bus_req",  ifn.bus_req, 1);
        check("t6_bus_addr", ifn.bus_addr, exp_phys(32'h9FFF_FFFC, 1'b0));
        ifn.bus_addr_ok = 1'b1;
        #1;
        check("t6_addr_ok", ifn.data_addr_ok, 1);
        @(posedge clk); #1;
        ifn.bus_addr_ok = 1'b0; ifn.data_req = 1'b0;
        ifn.bus_data_ok = 1'b1; ifn.bus_rdata = 32'h5A5A_0F0F;
        #1;
        check("t6_data_ok", ifn.data_data_ok, 1);
        check("t6_rdata",   ifn.data_rdata, 32'h5A5A_0F0F);
        @(posedge clk); #1;
        ifn.bus_data_ok = 1'b0;

        // Randomized request mixes
        for (int k = 0; k < 12; k++) begin
            new_d_payload();
            new_i_addr();
            run_mix($urandom_range(0, 3), $urandom_range(0, 6), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
